memory_manager: RTL and testbench

MEMORY_MANAGER -- requirements
Module: memory_manager

---
 rtl/memory_manager.sv | 197 +++++++++++++++++++
 tb/tb_memory_manager.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_manager.sv
// ---------------------------------------------------------------------------
// memory_manager
//
// Word-addressed memory system for the board-game controller. One access
// port fronts a general-purpose block RAM plus a small page of game-state
// registers. The current board bitmaps and game status are also presented
// as dedicated output ports. The raw sensor board, which is asynchronous to
// this clock, is brought in through a two-flop synchronizer and can be read
// back from the register page.
//
// Address map (word addresses):
//   0x0000_0000 - 0x0000_0FFF  RAM word addr[11:0]
//   0x0000_1000                player board  (read/write)
//   0x0000_1001                cpu board     (read/write)
//   0x0000_1002                king board    (read/write)
//   0x0000_1003                status        (read/write)
//   0x0000_1004                sensor board  (read-only, synchronized)
//   anything else              unmapped: reads 0, writes dropped
//
// Ports:
//   clock          rising-edge clock
//   reset          asynchronous active-low reset
//   wEn            write enable for the current access
//   addr           32-bit word address of the access
//   dataIn         write data
//   dataOut        read data, one cycle after addr is presented
//   sensorBoardIn  raw sensor bitmap (asynchronous)
//   playerBoardOut player-piece bitmap register
//   cpuBoardOut    CPU-piece bitmap register
//   kingBoardOut   king-piece bitmap register
//   statusOut      game status register
// ---------------------------------------------------------------------------
module memory_manager #(
  parameter int    RAM_ADDR_WIDTH = 12,
  parameter string MEMFILE        = ""
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wEn,
  input  logic [31:0] addr,
  input  logic [31:0] dataIn,
  output logic [31:0] dataOut,
  input  logic [31:0] sensorBoardIn,
  output logic [31:0] playerBoardOut,
  output logic [31:0] cpuBoardOut,
  output logic [31:0] kingBoardOut,
  output logic [31:0] statusOut
);

  localparam int RAM_DEPTH = 1 << RAM_ADDR_WIDTH;

  localparam logic [31:0] PLAYER_RESET = 32'h0000_0FFF;
  localparam logic [31:0] CPU_RESET    = 32'hFFF0_0000;

  localparam logic [2:0] IDX_PLAYER = 3'd0;
  localparam logic [2:0] IDX_CPU    = 3'd1;
  localparam logic [2:0] IDX_KING   = 3'd2;
  localparam logic [2:0] IDX_STATUS = 3'd3;
  localparam logic [2:0] IDX_SENSOR = 3'd4;

  // Which source the registered read data comes from. SRC_NONE doubles as
  // the reset state so dataOut reads zero until the first real access.
  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_RAM,
    SRC_REG
  } rd_src_t;

  // -------------------------------------------------------------------------
  // Address decode
  // -------------------------------------------------------------------------
  logic                      addr_is_ram;
  logic                      addr_is_reg;
  logic [2:0]                reg_index;
  logic [RAM_ADDR_WIDTH-1:0] ram_index;
  logic                      ram_we;

  // The register page only occupies 0x1000-0x1004. Every upper bit is
  // checked so that no other address aliases onto RAM or a register.
  assign addr_is_ram = (addr[31:12] == 20'd0);
  assign reg_index   = addr[2:0];
  assign addr_is_reg = (addr[31:13] == 19'd0) && addr[12] &&
                       (addr[11:3] == 9'd0) && (reg_index <= IDX_SENSOR);
  assign ram_index   = addr[RAM_ADDR_WIDTH-1:0];

  // The RAM has no reset, so its writes are gated by the reset level here.
  assign ram_we = wEn && addr_is_ram && reset;

  // -------------------------------------------------------------------------
  // Block RAM: one write port, synchronous read-first read port
  // -------------------------------------------------------------------------
  logic [31:0] ram [0:RAM_DEPTH-1];
  logic [31:0] ram_rdata_q;

  // Read-first: the read samples the array before this edge's write lands,
  // so a same-edge read of the written word returns the old contents.
  always_ff @(posedge clock) begin
    if (ram_we) begin
      ram[ram_index] <= dataIn;
    end
    ram_rdata_q <= ram[ram_index];
  end

  // -------------------------------------------------------------------------
  // Sensor synchronizer
  // -------------------------------------------------------------------------
  logic [31:0] sensor_sync1_q;
  logic [31:0] sensor_sync2_q;

  // Two flops in series to settle the asynchronous sensor bitmap; only the
  // second stage is ever observed by the rest of the design.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sensor_sync1_q <= 32'd0;
      sensor_sync2_q <= 32'd0;
    end else begin
      sensor_sync1_q <= sensorBoardIn;
      sensor_sync2_q <= sensor_sync1_q;
    end
  end

  // -------------------------------------------------------------------------
  // Game-state registers
  // -------------------------------------------------------------------------
  // Written on a clock edge with wEn; the sensor slot is read-only so a
  // write there falls through the case and is dropped.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      playerBoardOut <= PLAYER_RESET;
      cpuBoardOut    <= CPU_RESET;
      kingBoardOut   <= 32'd0;
      statusOut      <= 32'd0;
    end else if (wEn && addr_is_reg) begin
      case (reg_index)
        IDX_PLAYER: playerBoardOut <= dataIn;
        IDX_CPU:    cpuBoardOut    <= dataIn;
        IDX_KING:   kingBoardOut   <= dataIn;
        IDX_STATUS: statusOut      <= dataIn;
        default:    ;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Register-page read mux (pre-edge values)
  // -------------------------------------------------------------------------
  logic [31:0] reg_read_value;

  always_comb begin
    reg_read_value = 32'd0;
    case (reg_index)
      IDX_PLAYER: reg_read_value = playerBoardOut;
      IDX_CPU:    reg_read_value = cpuBoardOut;
      IDX_KING:   reg_read_value = kingBoardOut;
      IDX_STATUS: reg_read_value = statusOut;
      IDX_SENSOR: reg_read_value = sensor_sync2_q;
      default:    reg_read_value = 32'd0;
    endcase
  end

  // -------------------------------------------------------------------------
  // Read pipeline
  // -------------------------------------------------------------------------
  rd_src_t     rd_src_q;
  logic [31:0] reg_rdata_q;

  // Captures the register value and the source selection on the same edge
  // the RAM samples its array, so both paths share one cycle of latency.
  // Because these are non-blocking, a register written on this edge is
  // read with its old value.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rd_src_q    <= SRC_NONE;
      reg_rdata_q <= 32'd0;
    end else begin
      reg_rdata_q <= reg_read_value;
      if (addr_is_ram) begin
        rd_src_q <= SRC_RAM;
      end else if (addr_is_reg) begin
        rd_src_q <= SRC_REG;
      end else begin
        rd_src_q <= SRC_NONE;
      end
    end
  end

  // Final selection between already-registered values.
  always_comb begin
    dataOut = 32'd0;
    case (rd_src_q)
      SRC_RAM:  dataOut = ram_rdata_q;
      SRC_REG:  dataOut = reg_rdata_q;
      default:  dataOut = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_memory_manager.sv
// ---------------------------------------------------------------------------
// tb_memory_manager
//
// Self-checking bench for memory_manager. A behavioural model keeps the RAM
// as a plain array, the registers as plain variables and the sensor path as
// "the value seen two edges ago"; every access is compared against it.
// ---------------------------------------------------------------------------
module tb_memory_manager;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wEn = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] dataIn = 32'd0;
  logic [31:0] sensorBoardIn = 32'd0;
  logic [31:0] dataOut;
  logic [31:0] playerBoardOut;
  logic [31:0] cpuBoardOut;
  logic [31:0] kingBoardOut;
  logic [31:0] statusOut;

  int compared = 0;
  int mismatched = 0;

  memory_manager dut (
    .clock          (clock),
    .reset          (reset),
    .wEn            (wEn),
    .addr           (addr),
    .dataIn         (dataIn),
    .dataOut        (dataOut),
    .sensorBoardIn  (sensorBoardIn),
    .playerBoardOut (playerBoardOut),
    .cpuBoardOut    (cpuBoardOut),
    .kingBoardOut   (kingBoardOut),
    .statusOut      (statusOut)
  );

  always #5 clock = ~clock;

  // Reference model state
  logic [31:0] ram_m [0:4095];
  bit          ram_known [0:4095];
  logic [31:0] m_player;
  logic [31:0] m_cpu;
  logic [31:0] m_king;
  logic [31:0] m_status;
  logic [31:0] sens_hist1;
  logic [31:0] sens_hist2;
  logic [31:0] cur_sens = 32'd0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_player   = 32'h0000_0FFF;
    m_cpu      = 32'hFFF0_0000;
    m_king     = 32'd0;
    m_status   = 32'd0;
    sens_hist1 = 32'd0;
    sens_hist2 = 32'd0;
  endtask

  // Model read of a word address; known=0 for RAM words never written.
  task automatic modelRead(input logic [31:0] a, output logic [31:0] v, output bit known);
    known = 1'b1;
    v = 32'd0;
    if (a < 32'h1000) begin
      v = ram_m[a[11:0]];
      known = ram_known[a[11:0]];
    end else if (a == 32'h1000) v = m_player;
    else if (a == 32'h1001) v = m_cpu;
    else if (a == 32'h1002) v = m_king;
    else if (a == 32'h1003) v = m_status;
    else if (a == 32'h1004) v = sens_hist2;
  endtask

  task automatic modelWrite(input logic [31:0] a, input logic [31:0] d);
    if (a < 32'h1000) begin
      ram_m[a[11:0]] = d;
      ram_known[a[11:0]] = 1'b1;
    end else if (a == 32'h1000) m_player = d;
    else if (a == 32'h1001) m_cpu = d;
    else if (a == 32'h1002) m_king = d;
    else if (a == 32'h1003) m_status = d;
  endtask

  task automatic checkBoards(input string tag);
    checkOutput({tag, ".player"}, playerBoardOut, m_player);
    checkOutput({tag, ".cpu"}, cpuBoardOut, m_cpu);
    checkOutput({tag, ".king"}, kingBoardOut, m_king);
    checkOutput({tag, ".status"}, statusOut, m_status);
  endtask

  // One access: inputs driven at the falling edge, results sampled 1 time
  // unit after the rising edge and compared with the model.
  task automatic applyStimulus(input string tag, input bit we, input logic [31:0] a,
                               input logic [31:0] d, input logic [31:0] sens);
    logic [31:0] exp_rd;
    bit          known;
    @(negedge clock);
    wEn = we;
    addr = a;
    dataIn = d;
    sensorBoardIn = sens;
    cur_sens = sens;
    modelRead(a, exp_rd, known);
    @(posedge clock);
    #1;
    sens_hist2 = sens_hist1;
    sens_hist1 = sens;
    if (we) modelWrite(a, d);
    if (known) checkOutput({tag, ".dataOut"}, dataOut, exp_rd);
    checkBoards(tag);
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] unmapped [7];
    unmapped[0] = 32'h0000_1005;
    unmapped[1] = 32'h0000_1007;
    unmapped[2] = 32'h0000_1FFF;
    unmapped[3] = 32'h0000_2000;
    unmapped[4] = 32'h0000_3004;
    unmapped[5] = 32'h8000_1000;
    unmapped[6] = 32'h0001_1000;
    for (int i = 0; i < 4096; i++) ram_known[i] = 1'b0;
    modelReset();

    // Reset asserted: outputs forced regardless of clock
    #2 reset = 1'b0;
    #1;
    $display("[TB] reset asserted");
    checkOutput("rst.player", playerBoardOut, 32'h0000_0FFF);
    checkOutput("rst.cpu", cpuBoardOut, 32'hFFF0_0000);
    checkOutput("rst.king", kingBoardOut, 32'd0);
    checkOutput("rst.status", statusOut, 32'd0);
    checkOutput("rst.dataOut", dataOut, 32'd0);

    // Accesses presented during reset are suppressed
    wEn = 1'b1;
    addr = 32'h0000_1000;
    dataIn = 32'h0000_AAAA;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("rstwr.player", playerBoardOut, 32'h0000_0FFF);
    checkOutput("rstwr.dataOut", dataOut, 32'd0);

    // Release and issue the first access in the same cycle
    @(negedge clock);
    reset = 1'b1;
    wEn = 1'b1;
    addr = 32'h0000_1002;
    dataIn = 32'h0000_0077;
    @(posedge clock);
    #1;
    sens_hist2 = sens_hist1;
    sens_hist1 = cur_sens;
    modelWrite(32'h0000_1002, 32'h0000_0077);
    checkOutput("first.king", kingBoardOut, 32'h0000_0077);
    checkOutput("first.dataOut", dataOut, 32'd0);

    // RAM write then read
    applyStimulus("ramwr", 1'b1, 32'h5, 32'hDEAD_BEEF, cur_sens);
    applyStimulus("ramrd", 1'b0, 32'h5, 32'h0, cur_sens);
    checkOutput("ramrd.const", dataOut, 32'hDEAD_BEEF);

    // Player board write/read
    applyStimulus("plwr", 1'b1, 32'h1000, 32'h0000_0400, cur_sens);
    checkOutput("plwr.const", playerBoardOut, 32'h0000_0400);
    applyStimulus("plrd", 1'b0, 32'h1000, 32'h0, cur_sens);
    checkOutput("plrd.const", dataOut, 32'h0000_0400);

    // Read-before-write on status
    applyStimulus("rbw", 1'b1, 32'h1003, 32'h1, cur_sens);
    checkOutput("rbw.old", dataOut, 32'd0);
    applyStimulus("rbw2", 1'b0, 32'h1003, 32'h0, cur_sens);
    checkOutput("rbw2.new", dataOut, 32'h1);
    checkOutput("rbw2.status", statusOut, 32'h1);

    // RAM read-before-write
    applyStimulus("ramrbw", 1'b1, 32'h5, 32'h0BAD_F00D, cur_sens);
    checkOutput("ramrbw.old", dataOut, 32'hDEAD_BEEF);
    applyStimulus("ramrbw2", 1'b1, 32'h5, 32'hDEAD_BEEF, cur_sens);
    checkOutput("ramrbw2.new", dataOut, 32'h0BAD_F00D);

    // Sensor synchronizer latency
    applyStimulus("sens0", 1'b0, 32'h1004, 32'h0, 32'h0000_F00F);
    checkOutput("sens0.const", dataOut, 32'd0);
    applyStimulus("sens1", 1'b0, 32'h1004, 32'h0, 32'h0000_F00F);
    checkOutput("sens1.const", dataOut, 32'd0);
    applyStimulus("sens2", 1'b0, 32'h1004, 32'h0, 32'h0000_F00F);
    checkOutput("sens2.const", dataOut, 32'h0000_F00F);
    applyStimulus("senswr", 1'b1, 32'h1004, 32'hFFFF_FFFF, 32'h0000_F00F);
    applyStimulus("sensrd", 1'b0, 32'h1004, 32'h0, 32'h0000_F00F);
    checkOutput("sensrd.const", dataOut, 32'h0000_F00F);

    // Unmapped write and read
    applyStimulus("unmwr", 1'b1, 32'h2000, 32'h1234_5678, cur_sens);
    applyStimulus("unmrd", 1'b0, 32'h2000, 32'h0, cur_sens);
    checkOutput("unmrd.const", dataOut, 32'd0);
    applyStimulus("unmram", 1'b0, 32'h0, 32'h0, cur_sens);
    applyStimulus("unmram5", 1'b0, 32'h5, 32'h0, cur_sens);
    checkOutput("unmram5.const", dataOut, 32'hDEAD_BEEF);

    // Reset during a register write overrides it; RAM survives reset
    @(negedge clock);
    wEn = 1'b1;
    addr = 32'h0000_1001;
    dataIn = 32'h0000_ABCD;
    #2 reset = 1'b0;
    #1;
    checkOutput("midrst.cpu", cpuBoardOut, 32'hFFF0_0000);
    checkOutput("midrst.dataOut", dataOut, 32'd0);
    @(posedge clock);
    #1;
    checkOutput("midrst2.cpu", cpuBoardOut, 32'hFFF0_0000);
    @(negedge clock);
    reset = 1'b1;
    wEn = 1'b0;
    modelReset();
    @(posedge clock);
    #1;
    sens_hist2 = sens_hist1;
    sens_hist1 = cur_sens;
    checkBoards("postrst");
    applyStimulus("retain", 1'b0, 32'h5, 32'h0, cur_sens);
    checkOutput("retain.const", dataOut, 32'hDEAD_BEEF);

    // Preload RAM words used by the random phase
    for (int i = 0; i < 16; i++) begin
      applyStimulus("fill", 1'b1, i, $urandom, cur_sens);
    end
    applyStimulus("fillTop", 1'b1, 32'h0FFF, $urandom, cur_sens);

    // Randomized mix of RAM, register and unmapped accesses
    for (int n = 0; n < 300; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 9: ra = $urandom_range(0, 15);
        4, 5, 6:       ra = 32'h1000 + $urandom_range(0, 4);
        7:             ra = unmapped[$urandom_range(0, 6)];
        default:       ra = 32'h0FFF;
      endcase
      if ($urandom_range(0, 3) == 0) cur_sens = $urandom;
      applyStimulus("rand", 1'($urandom_range(0, 1)), ra, $urandom, cur_sens);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
